// File: rtl/pokey_input_pkg.sv
// Shared types and defaults for the POKEY keyboard/pot scanner.
package pokey_input_pkg;
  typedef enum logic [1:0] {IDLE, CONFIRM, HELD, RELEASE} deb_state_e;
  typedef enum logic {POT_IDLE, POT_SCAN} pot_state_e;

  localparam int DEF_POT_MAX  = 228;
  localparam int DEF_SCAN_DIV = 114;
endpackage

// File: rtl/pokey_input_scanner_if.sv
// Keyboard and potentiometer scanner signal bundle; slave side is the scanner.
interface pokey_input_scanner_if #(
  parameter int KEY_BITS = 6,
  parameter int NUM_POTS = 8
);
  logic                  kr_L_i;
  logic [NUM_POTS-1:0]   pot_scan_i;
  logic                  potgo_i;
  logic                  fast_pot_i;
  logic                  kbd_en_i;
  logic [KEY_BITS-1:0]   key_scan_L_o;
  logic [KEY_BITS-1:0]   keycode_o;
  logic                  key_depr_o;
  logic                  kbd_irq_o;
  logic                  pot_dump_o;
  logic [8*NUM_POTS-1:0] pot_val_o;
  logic [NUM_POTS-1:0]   allpot_o;
  logic                  pot_done_o;

  modport master (
    output kr_L_i, pot_scan_i, potgo_i, fast_pot_i, kbd_en_i,
    input  key_scan_L_o, keycode_o, key_depr_o, kbd_irq_o, pot_dump_o,
           pot_val_o, allpot_o, pot_done_o
  );

  modport slave (
    input  kr_L_i, pot_scan_i, potgo_i, fast_pot_i, kbd_en_i,
    output key_scan_L_o, keycode_o, key_depr_o, kbd_irq_o, pot_dump_o,
           pot_val_o, allpot_o, pot_done_o
  );
endinterface

// File: rtl/pokey_pot_channel.sv
// One pot channel: comparator synchroniser, still-counting flag and count latch.
module pokey_pot_channel (
  input  logic       o2,
  input  logic       RST,
  input  logic       pot_scan_i,
  input  logic       start_i,
  input  logic       step_i,
  input  logic       force_i,
  input  logic [7:0] cnt_i,
  output logic       active_o,
  output logic       hit_o,
  output logic [7:0] val_o
);
  logic       meta_q, sync_q, active_q, active_d;
  logic [7:0] val_q, val_d;

  // hit means this channel finishes on the current step (crossed or count exhausted)
  assign hit_o    = active_q & (sync_q | force_i);
  assign active_o = active_q;
  assign val_o    = val_q;

  always_comb begin
    active_d = active_q;
    val_d    = val_q;
    if (start_i) begin
      active_d = 1'b1;
    end else if (step_i && hit_o) begin
      active_d = 1'b0;
      val_d    = cnt_i;
    end
  end

  always_ff @(posedge o2 or posedge RST) begin
    if (RST) begin
      meta_q   <= 1'b0;
      sync_q   <= 1'b0;
      active_q <= 1'b0;
      val_q    <= '0;
    end else begin
      meta_q   <= pot_scan_i;
      sync_q   <= meta_q;
      active_q <= active_d;
      val_q    <= val_d;
    end
  end
endmodule

// File: rtl/pokey_input_scanner.sv
// Keyboard matrix scan with two-pass debounce, plus shared-counter pot scanner.
// state   | meaning
// IDLE    | no key pending; first low kr_L captures the code
// CONFIRM | waiting one full pass to see the same code low again
// HELD    | key latched; waiting for its code to read high
// RELEASE | waiting one full pass to confirm the release
module pokey_input_scanner
  import pokey_input_pkg::*;
#(
  parameter int KEY_BITS = 6,
  parameter int NUM_POTS = 8,
  parameter int POT_MAX  = DEF_POT_MAX,
  parameter int SCAN_DIV = DEF_SCAN_DIV
) (
  input logic o2,
  input logic RST,
  pokey_input_scanner_if.slave bus
);
  localparam int DIV_W = $clog2(SCAN_DIV);

  logic [DIV_W-1:0]    div_q, div_d;
  logic [KEY_BITS-1:0] scan_q, scan_d, cmp_q, cmp_d, keycode_q, keycode_d;
  logic                tick, match, kr_meta_q, kr_sync_q;
  logic                depr_q, depr_d, irq_q, irq_d;
  deb_state_e          deb_q, deb_d;
  pot_state_e          pot_q, pot_d;
  logic [7:0]          cnt_q, cnt_d;
  logic                done_q, done_d, step, scan_step, at_max, all_clear, start;
  logic [NUM_POTS-1:0] active, hit;
  logic [8*NUM_POTS-1:0] pot_val;

  assign tick   = (div_q == DIV_W'(SCAN_DIV - 1));
  assign div_d  = tick ? '0 : div_q + 1'b1;
  assign scan_d = (tick && bus.kbd_en_i) ? scan_q + 1'b1 : scan_q;
  assign match  = (scan_q == cmp_q);

  // The kr_L sample taken on a tick belongs to the code that tick replaces.
  always_comb begin
    deb_d     = deb_q;
    cmp_d     = cmp_q;
    keycode_d = keycode_q;
    depr_d    = depr_q;
    irq_d     = 1'b0;
    if (!bus.kbd_en_i) begin
      deb_d  = IDLE;
      depr_d = 1'b0;
    end else if (tick) begin
      unique case (deb_q)
        IDLE: if (!kr_sync_q) begin
          cmp_d = scan_q;
          deb_d = CONFIRM;
        end
        CONFIRM: if (match) begin
          if (!kr_sync_q) begin
            keycode_d = cmp_q;
            depr_d    = 1'b1;
            irq_d     = 1'b1;
            deb_d     = HELD;
          end else begin
            deb_d = IDLE;
          end
        end
        HELD: if (match && kr_sync_q) deb_d = RELEASE;
        RELEASE: if (match) begin
          if (kr_sync_q) begin
            depr_d = 1'b0;
            deb_d  = IDLE;
          end else begin
            deb_d = HELD;
          end
        end
        default: deb_d = IDLE;
      endcase
    end
  end

  assign step      = bus.fast_pot_i | tick;
  assign scan_step = (pot_q == POT_SCAN) && step && !bus.potgo_i;
  assign at_max    = (cnt_q == 8'(POT_MAX));
  assign all_clear = ~|(active & ~hit);

  // Reaching POT_MAX forces every active channel to finish, so all_clear covers it.
  always_comb begin
    pot_d  = pot_q;
    cnt_d  = cnt_q;
    done_d = 1'b0;
    start  = 1'b0;
    if (bus.potgo_i) begin
      start = 1'b1;
      cnt_d = '0;
      pot_d = POT_SCAN;
    end else if (pot_q == POT_SCAN && step) begin
      if (all_clear) begin
        pot_d  = POT_IDLE;
        done_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge o2 or posedge RST) begin
    if (RST) begin
      div_q     <= '0;
      scan_q    <= '0;
      cmp_q     <= '0;
      keycode_q <= '0;
      kr_meta_q <= 1'b1;
      kr_sync_q <= 1'b1;
      depr_q    <= 1'b0;
      irq_q     <= 1'b0;
      deb_q     <= IDLE;
      pot_q     <= POT_IDLE;
      cnt_q     <= '0;
      done_q    <= 1'b0;
    end else begin
      div_q     <= div_d;
      scan_q    <= scan_d;
      cmp_q     <= cmp_d;
      keycode_q <= keycode_d;
      kr_meta_q <= bus.kr_L_i;
      kr_sync_q <= kr_meta_q;
      depr_q    <= depr_d;
      irq_q     <= irq_d;
      deb_q     <= deb_d;
      pot_q     <= pot_d;
      cnt_q     <= cnt_d;
      done_q    <= done_d;
    end
  end

  for (genvar i = 0; i < NUM_POTS; i++) begin : g_pot
    pokey_pot_channel u_chan (
      .o2        (o2),
      .RST       (RST),
      .pot_scan_i(bus.pot_scan_i[i]),
      .start_i   (start),
      .step_i    (scan_step),
      .force_i   (at_max),
      .cnt_i     (cnt_q),
      .active_o  (active[i]),
      .hit_o     (hit[i]),
      .val_o     (pot_val[8*i +: 8])
    );
  end

  assign bus.key_scan_L_o = ~scan_q;
  assign bus.keycode_o    = keycode_q;
  assign bus.key_depr_o   = depr_q;
  assign bus.kbd_irq_o    = irq_q;
  assign bus.pot_dump_o   = (pot_q == POT_IDLE);
  assign bus.pot_val_o    = pot_val;
  assign bus.allpot_o     = active;
  assign bus.pot_done_o   = done_q;
endmodule

// File: tb/tb_pokey_input_scanner.sv
// Bench for pokey_input_scanner: keyboard matrix model, pot timing model, reset cases.
module tb_pokey_input_scanner;
  localparam int KB = 6, NP = 8, PM = 228, SD = 8, NEVER = 1000;

  logic o2 = 1'b0;
  logic RST;
  logic [63:0] keys;
  logic [KB-1:0] code_now;

  pokey_input_scanner_if #(.KEY_BITS(KB), .NUM_POTS(NP)) bus ();

  pokey_input_scanner #(.KEY_BITS(KB), .NUM_POTS(NP), .POT_MAX(PM), .SCAN_DIV(SD)) dut (
    .o2 (o2),
    .RST(RST),
    .bus(bus)
  );

  always #5 o2 = ~o2;

  // Keyboard matrix: return line pulled low while a pressed key's code is driven.
  assign code_now = ~bus.key_scan_L_o;
  always_comb bus.kr_L_i = ~keys[code_now];

  typedef int tvec_t [NP];
  typedef struct {
    tvec_t       t;
    logic [63:0] exp_val;
    int          exp_done;
  } pot_vec_t;

  int n_chk = 0, n_fail = 0;
  int samp, irq_cnt, irq_samp, fall_samp, done_cnt;
  logic [63:0] last_val = '0;
  pot_vec_t vecs [3];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic int vmin(input int t);
    return (t < PM) ? t : PM;
  endfunction

  task automatic check_reset(input string tag);
    chk({tag, "_key_scan_L"}, 64'(bus.key_scan_L_o), 64'h3F);
    chk({tag, "_keycode"},    64'(bus.keycode_o), 64'h0);
    chk({tag, "_key_depr"},   64'(bus.key_depr_o), 64'h0);
    chk({tag, "_kbd_irq"},    64'(bus.kbd_irq_o), 64'h0);
    chk({tag, "_pot_dump"},   64'(bus.pot_dump_o), 64'h1);
    chk({tag, "_pot_val"},    bus.pot_val_o, 64'h0);
    chk({tag, "_allpot"},     64'(bus.allpot_o), 64'h0);
    chk({tag, "_pot_done"},   64'(bus.pot_done_o), 64'h0);
  endtask

  task automatic clr_watch();
    samp = 0; irq_cnt = 0; irq_samp = -1; fall_samp = -1; done_cnt = 0;
  endtask

  // Observe n scan ticks; samp counts how many times `code` has been sampled.
  task automatic watch(input int n, input logic [KB-1:0] code);
    int ticks = 0, cyc = 0;
    logic [KB-1:0] prev = code_now;
    logic prev_depr = bus.key_depr_o;
    while (ticks < n && cyc < n * SD + 4 * SD) begin
      @(negedge o2);
      cyc++;
      if (code_now != prev) begin
        ticks++;
        if (prev == code) samp++;
      end
      if (bus.kbd_irq_o) begin irq_cnt++; irq_samp = samp; end
      if (bus.pot_done_o) done_cnt++;
      if (prev_depr && !bus.key_depr_o) fall_samp = samp;
      prev = code_now;
      prev_depr = bus.key_depr_o;
    end
    chk("watch_ticks", 64'(ticks), 64'(n));
  endtask

  task automatic wait_code(input logic [KB-1:0] c);
    int cyc = 0;
    while (code_now != c && cyc < 70 * SD) begin
      @(negedge o2);
      cyc++;
    end
    chk("wait_code", 64'(code_now), 64'(c));
  endtask

  // Fast-mode run: step k (count k) lands on edge k+1 after the potgo edge, and a
  // comparator raised before edge k-1 is seen through the synchroniser at step k.
  task automatic pot_run(input tvec_t t, input logic [63:0] exp_val, input int exp_done);
    int d_cnt = 0, d_c = -100;
    logic [NP-1:0] exp_ap;
    bus.fast_pot_i = 1'b1;
    bus.pot_scan_i = '0;
    repeat (4) @(negedge o2);
    for (int c = -1; c <= exp_done + 3; c++) begin
      @(negedge o2);
      if (c >= 0) begin
        for (int i = 0; i < NP; i++) exp_ap[i] = (c >= 1) && (c < vmin(t[i]) + 2);
        chk("allpot_track", 64'(bus.allpot_o), 64'(exp_ap));
      end
      if (bus.pot_done_o) begin d_cnt++; d_c = c; end
      if (c == 1) chk("pot_dump_scan", 64'(bus.pot_dump_o), 64'h0);
      for (int i = 0; i < NP; i++) bus.pot_scan_i[i] = (c >= t[i] - 1);
      bus.potgo_i = (c == 0);
    end
    chk("pot_done_count", 64'(d_cnt), 64'h1);
    chk("pot_done_cycle", 64'(d_c), 64'(exp_done));
    chk("pot_val", bus.pot_val_o, exp_val);
    chk("pot_dump_end", 64'(bus.pot_dump_o), 64'h1);
    last_val = exp_val;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    tvec_t rt;
    logic [63:0] rv;
    int m, ticks, cyc;
    logic [KB-1:0] prev, held_code;

    vecs[0].t = '{40, NEVER, NEVER, NEVER, NEVER, NEVER, NEVER, NEVER};
    vecs[0].exp_val = {{7{8'd228}}, 8'd40};
    vecs[0].exp_done = 230;
    vecs[1].t = '{0, 1, 2, 3, 5, 8, 13, 21};
    vecs[1].exp_val = {8'd21, 8'd13, 8'd8, 8'd5, 8'd3, 8'd2, 8'd1, 8'd0};
    vecs[1].exp_done = 23;
    vecs[2].t = '{100, 227, 228, 229, 0, 50, 300, 7};
    vecs[2].exp_val = {8'd7, 8'd228, 8'd50, 8'd0, 8'd228, 8'd228, 8'd227, 8'd100};
    vecs[2].exp_done = 230;

    RST = 1'b1;
    keys = '0;
    bus.potgo_i = 1'b0;
    bus.fast_pot_i = 1'b0;
    bus.kbd_en_i = 1'b1;
    bus.pot_scan_i = '0;
    repeat (3) @(negedge o2);
    check_reset("por");
    RST = 1'b0;

    for (int v = 0; v < 3; v++) pot_run(vecs[v].t, vecs[v].exp_val, vecs[v].exp_done);

    for (int r = 0; r < 6; r++) begin
      m = 0;
      rv = '0;
      for (int i = 0; i < NP; i++) begin
        rt[i] = ($urandom_range(0, 3) == 0) ? NEVER : int'($urandom_range(0, 240));
        rv[8*i +: 8] = 8'(vmin(rt[i]));
        if (vmin(rt[i]) > m) m = vmin(rt[i]);
      end
      pot_run(rt, rv, m + 2);
    end

    // Slow mode: restart at count 100, then every channel crosses at once.
    bus.fast_pot_i = 1'b0;
    bus.pot_scan_i = '0;
    repeat (4) @(negedge o2);
    bus.potgo_i = 1'b1;
    @(negedge o2);
    bus.potgo_i = 1'b0;
    prev = code_now;
    ticks = 0;
    cyc = 0;
    while (ticks < 100 && cyc < 100 * SD + 50) begin
      @(negedge o2);
      cyc++;
      if (code_now != prev) ticks++;
      prev = code_now;
    end
    chk("slow_ticks", 64'(ticks), 64'd100);
    chk("slow_allpot_mid", 64'(bus.allpot_o), 64'hFF);
    bus.potgo_i = 1'b1;
    @(negedge o2);
    bus.potgo_i = 1'b0;
    chk("restart_allpot", 64'(bus.allpot_o), 64'hFF);
    chk("restart_dump", 64'(bus.pot_dump_o), 64'h0);
    chk("restart_retained", bus.pot_val_o, last_val);
    bus.pot_scan_i = '1;
    m = 0;
    for (int c = 0; c < 4 * SD; c++) begin
      @(negedge o2);
      if (bus.pot_done_o) m++;
    end
    chk("restart_done", 64'(m), 64'h1);
    chk("restart_val", bus.pot_val_o, 64'h0);
    chk("restart_dump_end", 64'(bus.pot_dump_o), 64'h1);
    bus.pot_scan_i = '0;

    // Press 0x0C: irq on the second sample of that code.
    wait_code(6'h00);
    clr_watch();
    keys[12] = 1'b1;
    watch(192, 6'h0C);
    chk("press_irq_cnt", 64'(irq_cnt), 64'h1);
    chk("press_irq_pass", 64'(irq_samp), 64'h2);
    chk("press_keycode", 64'(bus.keycode_o), 64'h0C);
    chk("press_depr", 64'(bus.key_depr_o), 64'h1);

    // Second key while held is ignored; release takes two passes.
    clr_watch();
    keys[48] = 1'b1;
    watch(128, 6'h30);
    wait_code(6'h00);
    chk("held_depr", 64'(bus.key_depr_o), 64'h1);
    keys[48] = 1'b0;
    keys[12] = 1'b0;
    samp = 0;
    watch(192, 6'h0C);
    chk("release_irq_cnt", 64'(irq_cnt), 64'h0);
    chk("release_keycode", 64'(bus.keycode_o), 64'h0C);
    chk("release_fall_pass", 64'(fall_samp), 64'h2);
    chk("release_depr", 64'(bus.key_depr_o), 64'h0);

    // Single-pass glitch at 0x21.
    clr_watch();
    wait_code(6'h00);
    keys[33] = 1'b1;
    wait_code(6'h22);
    keys[33] = 1'b0;
    watch(128, 6'h21);
    chk("glitch_irq_cnt", 64'(irq_cnt), 64'h0);
    chk("glitch_keycode", 64'(bus.keycode_o), 64'h0C);
    chk("glitch_depr", 64'(bus.key_depr_o), 64'h0);

    // A fresh press after the glitch latches normally.
    clr_watch();
    wait_code(6'h00);
    keys[5] = 1'b1;
    watch(192, 6'h05);
    chk("post_glitch_irq_pass", 64'(irq_samp), 64'h2);
    chk("post_glitch_keycode", 64'(bus.keycode_o), 64'h05);

    // Disabling the keyboard freezes the scan code and drops key_depr.
    bus.kbd_en_i = 1'b0;
    @(negedge o2);
    held_code = code_now;
    keys[5] = 1'b0;
    repeat (3 * SD) @(negedge o2);
    chk("kbd_off_depr", 64'(bus.key_depr_o), 64'h0);
    chk("kbd_off_code_hold", 64'(code_now), 64'(held_code));
    bus.kbd_en_i = 1'b1;

    // Reset in the middle of CONFIRM and a slow pot scan.
    bus.potgo_i = 1'b1;
    @(negedge o2);
    bus.potgo_i = 1'b0;
    wait_code(6'h00);
    keys[12] = 1'b1;
    wait_code(6'h0D);
    @(negedge o2);
    RST = 1'b1;
    keys = '0;
    #1;
    check_reset("mid_async");
    @(negedge o2);
    check_reset("mid_cycle");
    RST = 1'b0;
    @(negedge o2);
    chk("post_rst_scan", 64'(bus.key_scan_L_o), 64'h3F);
    clr_watch();
    watch(128, 6'h0C);
    chk("post_rst_irq", 64'(irq_cnt), 64'h0);
    chk("post_rst_done", 64'(done_cnt), 64'h0);
    chk("post_rst_keycode", 64'(bus.keycode_o), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
